// File: rtl/chacha_block_ctr_if.sv
// Load/issue bundle between the ChaCha20 block-counter sequencer and its controller/consumer.
// The slave side is the sequencer; the master side loads messages and accepts counter groups.
interface chacha_block_ctr_if #(
    parameter int CTR_W = 32,
    parameter int LANES = 4,
    parameter int LEN_W = 16
);
    logic                   load;
    logic [CTR_W-1:0]       load_ctr;
    logic [LEN_W-1:0]       load_nblk;
    logic                   issue_ready;
    logic                   issue_valid;
    logic [LANES*CTR_W-1:0] issue_ctr;
    logic [LANES-1:0]       issue_mask;
    logic                   issue_last;
    logic                   done;
    logic                   ovf_err;
    logic                   busy;

    modport master (
        output load, load_ctr, load_nblk, issue_ready,
        input  issue_valid, issue_ctr, issue_mask, issue_last, done, ovf_err, busy
    );

    modport slave (
        input  load, load_ctr, load_nblk, issue_ready,
        output issue_valid, issue_ctr, issue_mask, issue_last, done, ovf_err, busy
    );
endinterface

// File: rtl/chacha_block_ctr.sv
// ChaCha20 block-counter sequencer: issues LANES consecutive counters per accepted group.
// Outputs decode from registers only (load -> first group next cycle); a stalled group holds stable.
module chacha_block_ctr #(
    parameter int CTR_W = 32,
    parameter int LANES = 4,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    chacha_block_ctr_if.slave bus
);
    localparam int SUM_W = CTR_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} state_t;

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [SUM_W-1:0]   load_end;
    logic               load_ovf;
    logic               is_run;
    logic               last;
    logic               xfer;
    logic [LANES*CTR_W-1:0] ctr_vec;
    logic [LANES-1:0]   mask_vec;

    // End of the requested range may touch 2^CTR_W exactly, but never exceed it.
    assign load_end = {1'b0, bus.load_ctr} + SUM_W'(bus.load_nblk);
    assign load_ovf = load_end[CTR_W] && (load_end[CTR_W-1:0] != '0);

    assign is_run = (state_q == ST_RUN);
    assign last   = (rem_q <= LEN_W'(LANES));
    assign xfer   = is_run && bus.issue_ready;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        rem_d   = rem_q;
        if (bus.load) begin
            // A load wins over a same-cycle handshake; the accepted group is simply dropped here.
            if (load_ovf) begin
                state_d = ST_ERR;
            end else if (bus.load_nblk == '0) begin
                state_d = ST_DONE;
            end else begin
                state_d = ST_RUN;
                base_d  = bus.load_ctr;
                rem_d   = bus.load_nblk;
            end
        end else if (xfer) begin
            base_d = base_q + CTR_W'(LANES);
            rem_d  = last ? '0 : rem_q - LEN_W'(LANES);
            if (last) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        ctr_vec  = '0;
        mask_vec = '0;
        for (int i = 0; i < LANES; i++) begin
            if (is_run && (rem_q > LEN_W'(i))) begin
                mask_vec[i]                = 1'b1;
                ctr_vec[i*CTR_W +: CTR_W]  = base_q + CTR_W'(i);
            end
        end
    end

    assign bus.issue_valid = is_run;
    assign bus.issue_ctr   = ctr_vec;
    assign bus.issue_mask  = mask_vec;
    assign bus.issue_last  = is_run && last;
    assign bus.busy        = is_run;
    assign bus.done        = (state_q == ST_DONE);
    assign bus.ovf_err     = (state_q == ST_ERR);
endmodule

// File: tb/tb_chacha_block_ctr.sv
// Directed bench for chacha_block_ctr: reset, issue sequence, backpressure, counter boundary, reload.
module tb_chacha_block_ctr;
    localparam int CTR_W = 32;
    localparam int LANES = 4;
    localparam int LEN_W = 16;
    localparam int OV_W  = 5 + LANES + LANES*CTR_W;

    typedef logic [OV_W-1:0] ovec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [LANES*CTR_W-1:0] exp_ctr  [3];
    logic [LANES-1:0]       exp_mask [3];
    logic                   exp_last [3];

    always #5 clk = ~clk;

    chacha_block_ctr_if #(.CTR_W(CTR_W), .LANES(LANES), .LEN_W(LEN_W)) bus ();

    chacha_block_ctr #(.CTR_W(CTR_W), .LANES(LANES), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Observation order: valid, last, done, ovf_err, busy, mask, ctr
    function automatic ovec_t obs_vec();
        return {bus.issue_valid, bus.issue_last, bus.done, bus.ovf_err, bus.busy,
                bus.issue_mask, bus.issue_ctr};
    endfunction

    function automatic ovec_t run_vec(input logic lst, input logic [LANES-1:0] m,
                                      input logic [LANES*CTR_W-1:0] c);
        return {1'b1, lst, 1'b0, 1'b0, 1'b1, m, c};
    endfunction

    function automatic ovec_t done_vec();
        ovec_t v;
        v = '0;
        v[OV_W-3] = 1'b1;
        return v;
    endfunction

    function automatic ovec_t err_vec();
        ovec_t v;
        v = '0;
        v[OV_W-4] = 1'b1;
        return v;
    endfunction

    task automatic do_load(input logic [CTR_W-1:0] c, input logic [LEN_W-1:0] n);
        @(negedge clk);
        bus.load      = 1'b1;
        bus.load_ctr  = c;
        bus.load_nblk = n;
        @(negedge clk);
        bus.load      = 1'b0;
    endtask

    task automatic set_basic_table();
        exp_ctr[0]  = {32'd4, 32'd3, 32'd2, 32'd1};
        exp_mask[0] = 4'b1111;
        exp_last[0] = 1'b0;
        exp_ctr[1]  = {32'd8, 32'd7, 32'd6, 32'd5};
        exp_mask[1] = 4'b1111;
        exp_last[1] = 1'b0;
        exp_ctr[2]  = {32'd0, 32'd0, 32'd10, 32'd9};
        exp_mask[2] = 4'b0011;
        exp_last[2] = 1'b1;
    endtask

    task automatic test_reset();
        ovec_t o;
        rst_n           = 1'b1;
        bus.load        = 1'b0;
        bus.load_ctr    = '0;
        bus.load_nblk   = '0;
        bus.issue_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        o = obs_vec();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", o, ovec_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.issue_ready = 1'b1;
        @(negedge clk);
        o = obs_vec();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", o, ovec_t'(0));
        end
    endtask

    task automatic test_basic();
        ovec_t o;
        set_basic_table();
        bus.issue_ready = 1'b1;
        do_load(32'd1, 16'd10);
        for (int g = 0; g < 3; g++) begin
            o = obs_vec();
            checks++;
            if (o !== run_vec(exp_last[g], exp_mask[g], exp_ctr[g])) begin
                errors++;
                $display("FAIL basic_group%0d: got %h expected %h", g, o,
                         run_vec(exp_last[g], exp_mask[g], exp_ctr[g]));
            end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            o = obs_vec();
            checks++;
            if (o !== done_vec()) begin
                errors++;
                $display("FAIL basic_done%0d: got %h expected %h", k, o, done_vec());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        ovec_t o;
        set_basic_table();
        bus.issue_ready = 1'b1;
        do_load(32'd1, 16'd10);
        o = obs_vec();
        checks++;
        if (o !== run_vec(exp_last[0], exp_mask[0], exp_ctr[0])) begin
            errors++;
            $display("FAIL bp_group0: got %h expected %h", o, run_vec(exp_last[0], exp_mask[0], exp_ctr[0]));
        end
        @(negedge clk);
        bus.issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.issue_ready = 1'b1;
            o = obs_vec();
            checks++;
            if (o !== run_vec(exp_last[1], exp_mask[1], exp_ctr[1])) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h expected %h", k, o, run_vec(exp_last[1], exp_mask[1], exp_ctr[1]));
            end
            @(negedge clk);
        end
        o = obs_vec();
        checks++;
        if (o !== run_vec(exp_last[2], exp_mask[2], exp_ctr[2])) begin
            errors++;
            $display("FAIL bp_group2: got %h expected %h", o, run_vec(exp_last[2], exp_mask[2], exp_ctr[2]));
        end
        @(negedge clk);
        o = obs_vec();
        checks++;
        if (o !== done_vec()) begin
            errors++;
            $display("FAIL bp_done: got %h expected %h", o, done_vec());
        end
    endtask

    task automatic test_boundary();
        ovec_t o;
        bus.issue_ready = 1'b1;
        do_load(32'hFFFF_FFFE, 16'd2);
        o = obs_vec();
        checks++;
        if (o !== run_vec(1'b1, 4'b0011, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE})) begin
            errors++;
            $display("FAIL bound_group: got %h expected %h", o,
                     run_vec(1'b1, 4'b0011, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE}));
        end
        @(negedge clk);
        o = obs_vec();
        checks++;
        if (o !== done_vec()) begin
            errors++;
            $display("FAIL bound_done: got %h expected %h", o, done_vec());
        end
        do_load(32'hFFFF_FFFE, 16'd3);
        for (int k = 0; k < 3; k++) begin
            o = obs_vec();
            checks++;
            if (o !== err_vec()) begin
                errors++;
                $display("FAIL bound_ovf%0d: got %h expected %h", k, o, err_vec());
            end
            @(negedge clk);
        end
        do_load(32'hFFFF_FFFF, 16'd1);
        o = obs_vec();
        checks++;
        if (o !== run_vec(1'b1, 4'b0001, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF})) begin
            errors++;
            $display("FAIL bound_top_lane: got %h expected %h", o,
                     run_vec(1'b1, 4'b0001, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}));
        end
        @(negedge clk);
        o = obs_vec();
        checks++;
        if (o !== done_vec()) begin
            errors++;
            $display("FAIL bound_top_done: got %h expected %h", o, done_vec());
        end
    endtask

    task automatic test_zero_len();
        ovec_t o;
        bus.issue_ready = 1'b1;
        do_load(32'd7, 16'd0);
        for (int k = 0; k < 3; k++) begin
            o = obs_vec();
            checks++;
            if (o !== done_vec()) begin
                errors++;
                $display("FAIL zero_len%0d: got %h expected %h", k, o, done_vec());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reload();
        ovec_t o;
        set_basic_table();
        bus.issue_ready = 1'b1;
        do_load(32'd1, 16'd10);
        o = obs_vec();
        checks++;
        if (o !== run_vec(exp_last[0], exp_mask[0], exp_ctr[0])) begin
            errors++;
            $display("FAIL reload_group0: got %h expected %h", o, run_vec(exp_last[0], exp_mask[0], exp_ctr[0]));
        end
        bus.load      = 1'b1;
        bus.load_ctr  = 32'd100;
        bus.load_nblk = 16'd4;
        @(negedge clk);
        bus.load = 1'b0;
        o = obs_vec();
        checks++;
        if (o !== run_vec(1'b1, 4'b1111, {32'd103, 32'd102, 32'd101, 32'd100})) begin
            errors++;
            $display("FAIL reload_group: got %h expected %h", o,
                     run_vec(1'b1, 4'b1111, {32'd103, 32'd102, 32'd101, 32'd100}));
        end
        @(negedge clk);
        o = obs_vec();
        checks++;
        if (o !== done_vec()) begin
            errors++;
            $display("FAIL reload_done: got %h expected %h", o, done_vec());
        end
    endtask

    task automatic test_reset_mid_run();
        ovec_t o;
        bus.issue_ready = 1'b0;
        do_load(32'd1, 16'd10);
        o = obs_vec();
        checks++;
        if (o !== run_vec(exp_last[0], exp_mask[0], exp_ctr[0])) begin
            errors++;
            $display("FAIL midrst_running: got %h expected %h", o, run_vec(exp_last[0], exp_mask[0], exp_ctr[0]));
        end
        #2 rst_n = 1'b0;
        #1;
        o = obs_vec();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL midrst_async: got %h expected %h", o, ovec_t'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.issue_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            o = obs_vec();
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL midrst_idle%0d: got %h expected %h", k, o, ovec_t'(0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_boundary();
        test_zero_len();
        test_reload();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
